// File: rtl/hex_display_scheduler.sv
// Time-shares one combinational hex-to-seven-segment decoder across NUM_DIGITS digits.
// A captured value is walked nibble by nibble; each returned pattern is latched per digit.
module hex_display_scheduler #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter logic [6:0]  BLANK_PATTERN = 7'h7F
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic                      lz_en,
    output logic                      ready,
    output logic                      done,
    output logic [3:0]                dec_a,
    input  logic [6:0]                dec_seg,
    output logic [7*NUM_DIGITS-1:0]   seg_out
);

    localparam int unsigned      IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WRITE,
        DONE
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [IDX_W-1:0]          idx;
    logic [4*NUM_DIGITS-1:0]   shadow;
    logic                      lz_flag;
    logic [7*NUM_DIGITS-1:0]   seg_reg;
    logic [3:0]                nibble;
    logic                      upper_zero;
    logic                      blank;
    logic [6:0]                wr_pattern;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (load) next_state = DECODE;
            DECODE:  next_state = WRITE;
            WRITE:   next_state = (idx == LAST_IDX) ? DONE : DECODE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Current nibble, and whether it and every more significant nibble are zero.
    always_comb begin
        nibble     = '0;
        upper_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nibble = shadow[4*k +: 4];
            end
            if ((IDX_W'(k) >= idx) && (shadow[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    // Digit 0 is never blanked so a zero value still shows a single "0".
    assign blank      = lz_flag && (idx != '0) && upper_zero;
    assign wr_pattern = blank ? BLANK_PATTERN : dec_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            shadow  <= '0;
            lz_flag <= 1'b0;
        end else begin
            if (state == IDLE && load) begin
                idx     <= '0;
                shadow  <= value;
                lz_flag <= lz_en;
            end else if (state == WRITE && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg <= {NUM_DIGITS{BLANK_PATTERN}};
        end else if (state == WRITE) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (idx == IDX_W'(k)) begin
                    seg_reg[7*k +: 7] <= wr_pattern;
                end
            end
        end
    end

    assign ready   = (state == IDLE);
    assign done    = (state == DONE);
    assign dec_a   = (state == DECODE || state == WRITE) ? nibble : 4'h0;
    assign seg_out = seg_reg;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler: decoder modelled in the loop, cycle-accurate
// expectations derived from the load time and the captured value.
module tb_hex_display_scheduler;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic          lz_en;
    logic [15:0]   value;
    logic          ready;
    logic          done;
    logic [3:0]    dec_a;
    logic [6:0]    dec_seg;
    logic [27:0]   seg_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] disp [N];

    always #5 clk = ~clk;

    // Active-low gfedcba hex font, as on the board displays.
    function automatic logic [6:0] hex_code(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    assign dec_seg = hex_code(dec_a);

    hex_display_scheduler #(
        .NUM_DIGITS    (N),
        .BLANK_PATTERN (7'h7F)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .load    (load),
        .lz_en   (lz_en),
        .ready   (ready),
        .done    (done),
        .dec_a   (dec_a),
        .dec_seg (dec_seg),
        .seg_out (seg_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] pack_disp();
        logic [27:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[7*k +: 7] = disp[k];
        return r;
    endfunction

    function automatic logic [6:0] ref_digit(input logic [15:0] v, input logic lz, input int k);
        logic [15:0] upper;
        upper = v >> (4 * k);
        if (lz && k > 0 && upper == 16'h0) return 7'h7F;
        return hex_code(upper[3:0]);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'(1'b1));
        check({tag, "_done"}, 64'(done), 64'(1'b0));
        check({tag, "_dec_a"}, 64'(dec_a), 64'(4'h0));
        check({tag, "_seg"}, 64'(seg_out), 64'({N{7'h7F}}));
    endtask

    // Entered and left at posedge+1.
    task automatic wait_ready();
        int i = 0;
        while (!ready && i < 50) begin
            @(posedge clk); #1;
            i++;
        end
        check("ready_wait", 64'(ready), 64'(1'b1));
    endtask

    task automatic run_update(input logic [15:0] v, input logic lz, input bit mangle, input int abort_at);
        logic [6:0]  nd [N];
        logic [15:0] sh;
        for (int k = 0; k < N; k++) nd[k] = ref_digit(v, lz, k);
        wait_ready();
        value = v; lz_en = lz; load = 1'b1;
        @(negedge clk);
        check("accept_ready", 64'(ready), 64'(1'b1));
        @(posedge clk); #1;
        load = 1'b0;
        for (int c = 1; c <= 2*N + 2; c++) begin
            if (mangle && c == 2) value = 16'($urandom);
            if (mangle && c == 4) begin
                load = 1'b1; value = 16'h1111; lz_en = ~lz;
            end
            if (c == abort_at) begin
                #2 rst = 1'b1;
                #1;
                for (int k = 0; k < N; k++) disp[k] = 7'h7F;
                check_reset_outputs("abort");
                for (int h = 0; h < 2; h++) begin
                    @(negedge clk);
                    check_reset_outputs("abort_hold");
                end
                @(posedge clk); #3;
                rst = 1'b0;
                @(negedge clk);
                check("abort_no_done", 64'(done), 64'(1'b0));
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            sh = v >> (4 * ((c - 1) / 2));
            check("dec_a", 64'(dec_a), (c <= 2*N) ? 64'(sh[3:0]) : 64'(4'h0));
            check("done", 64'(done), 64'(c == 2*N + 1));
            check("ready", 64'(ready), 64'(c == 2*N + 2));
            for (int k = 0; k < N; k++) if (c == 3 + 2*k) disp[k] = nd[k];
            check("seg_out", 64'(seg_out), 64'(pack_disp()));
            @(posedge clk); #1;
            load = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; value = '0; lz_en = 1'b0;
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) disp[k] = 7'h7F;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        run_update(16'h1234, 1'b0, 1'b0, 0);
        run_update(16'h0050, 1'b1, 1'b0, 0);
        run_update(16'h0050, 1'b0, 1'b0, 0);
        run_update(16'h0000, 1'b1, 1'b0, 0);
        run_update(16'hABCD, 1'b0, 1'b1, 0);
        run_update(16'hFFFF, 1'b0, 1'b0, 5);
        run_update(16'h0001, 1'b0, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [15:0] rv;
            rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
            run_update(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
